// File: rtl/decode_pipe_ctrl.sv
// decode_pipe_ctrl: registered, handshaked decode stage for the 16-bit ISA.
// Sits between fetch (in_*) and execute/memory (out_*). It stalls on load-use
// hazards through a per-register countdown scoreboard, kills the decoded
// bundle on flush, and parks in HALT once an HLT has been decoded.
// Optional feature macro: STALL_CNT_EN adds a saturating 16-bit stall counter.
module decode_pipe_ctrl #(
    parameter int unsigned OPC_W   = 4,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned INSTR_W = OPC_W + 3*REG_AW,
    parameter int unsigned LD_LAT  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               z_flag,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               rd_en1,
    output logic               rd_en2,
    output logic               wr_en,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               saw_br,
    output logic               saw_j,
    output logic               alu_src,
    output logic               hlt,
    output logic [REG_AW-1:0]  rd_reg1,
    output logic [REG_AW-1:0]  rd_reg2,
    output logic [REG_AW-1:0]  wr_reg,
    output logic [3:0]         alu_op,
    output logic [REG_AW-1:0]  sh_amt,
    output logic               halted
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int unsigned NUM_REGS = 2**REG_AW;
    localparam int unsigned CNT_W    = 3;

    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ADDZ = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_NOR  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_SLL  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SRL  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_SRA  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_LHB  = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_LLB  = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_B    = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(15);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_NOR = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;
    localparam logic [3:0] ALU_SRL = 4'd5;
    localparam logic [3:0] ALU_SRA = 4'd6;
    localparam logic [3:0] ALU_LHB = 4'd7;
    localparam logic [3:0] ALU_NOP = 4'd15;

    typedef enum logic {ST_RUN, ST_HALT} state_e;

    typedef struct packed {
        logic              rd_en1;
        logic              rd_en2;
        logic              wr_en;
        logic              mem_rd;
        logic              mem_wr;
        logic              saw_br;
        logic              saw_j;
        logic              alu_src;
        logic              hlt;
        logic [REG_AW-1:0] rd_reg1;
        logic [REG_AW-1:0] rd_reg2;
        logic [REG_AW-1:0] wr_reg;
        logic [3:0]        alu_op;
        logic [REG_AW-1:0] sh_amt;
    } ctl_t;

    logic [OPC_W-1:0]  opc;
    logic [REG_AW-1:0] f_rd, f_rs, f_rt;
    ctl_t              dec;
    logic              hazard;
    logic              accept;
    logic              out_hs;

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    ctl_t              ctl_q, ctl_d;
    logic [CNT_W-1:0]  pend_q [NUM_REGS];
    logic [CNT_W-1:0]  pend_d [NUM_REGS];

    assign opc  = instr[INSTR_W-1 -: OPC_W];
    assign f_rd = instr[3*REG_AW-1 -: REG_AW];
    assign f_rs = instr[2*REG_AW-1 -: REG_AW];
    assign f_rt = instr[REG_AW-1:0];

    // Combinational decode of the presented instruction into a control bundle.
    always_comb begin
        dec         = '0;
        dec.rd_reg1 = f_rs;
        dec.rd_reg2 = f_rt;
        dec.wr_reg  = f_rd;
        dec.sh_amt  = f_rt;
        dec.alu_op  = ALU_NOP;
        case (opc)
            OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR: begin
                dec.rd_en1 = 1'b1;
                dec.rd_en2 = 1'b1;
                dec.wr_en  = (opc != OP_ADDZ) || z_flag;
            end
            OP_SLL, OP_SRL, OP_SRA, OP_LHB, OP_LLB, OP_LW: begin
                dec.rd_en1 = 1'b1;
                dec.wr_en  = 1'b1;
            end
            OP_SW: begin
                dec.rd_en1  = 1'b1;
                dec.rd_en2  = 1'b1;
                dec.mem_wr  = 1'b1;
                dec.rd_reg2 = f_rd;
            end
            OP_B:   dec.saw_br = 1'b1;
            OP_JAL: begin
                dec.wr_en  = 1'b1;
                dec.wr_reg = '1;
                dec.saw_j  = 1'b1;
            end
            OP_JR: begin
                dec.rd_en1  = 1'b1;
                dec.rd_en2  = 1'b1;
                dec.rd_reg1 = '1;
                dec.rd_reg2 = '0;
                dec.saw_j   = 1'b1;
            end
            OP_HLT: dec.hlt = 1'b1;
            default: ;
        endcase
        dec.mem_rd = (opc == OP_LW);
        if (opc == OP_LHB) dec.rd_reg1 = f_rd;
        if (opc == OP_LLB) dec.rd_reg1 = '0;
        dec.alu_src = dec.rd_en2 && !(opc == OP_SW || opc == OP_LLB);
        case (opc)
            OP_ADD, OP_ADDZ, OP_LLB, OP_LW, OP_SW, OP_JR: dec.alu_op = ALU_ADD;
            OP_SUB: dec.alu_op = ALU_SUB;
            OP_AND: dec.alu_op = ALU_AND;
            OP_NOR: dec.alu_op = ALU_NOR;
            OP_SLL: dec.alu_op = ALU_SLL;
            OP_SRL: dec.alu_op = ALU_SRL;
            OP_SRA: dec.alu_op = ALU_SRA;
            OP_LHB: dec.alu_op = ALU_LHB;
            default: dec.alu_op = ALU_NOP;
        endcase
    end

    // Load-use hazard: a pending load, or a load sitting in the output register.
    always_comb begin
        hazard = 1'b0;
        if (dec.rd_en1 && dec.rd_reg1 != '0 &&
            (pend_q[dec.rd_reg1] != '0 ||
             (out_valid_q && ctl_q.mem_rd && ctl_q.wr_reg == dec.rd_reg1)))
            hazard = 1'b1;
        if (dec.rd_en2 && dec.rd_reg2 != '0 &&
            (pend_q[dec.rd_reg2] != '0 ||
             (out_valid_q && ctl_q.mem_rd && ctl_q.wr_reg == dec.rd_reg2)))
            hazard = 1'b1;
    end

    assign in_ready = (state_q == ST_RUN) && !flush && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready && !flush;

    // Next state and output register; flush overrides any downstream accept.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        ctl_d       = ctl_q;
        if (flush) begin
            out_valid_d = 1'b0;
            if (out_valid_q && ctl_q.hlt) state_d = ST_RUN;
        end else if (!out_valid_q || out_ready) begin
            out_valid_d = accept;
            if (accept) begin
                ctl_d = dec;
                if (dec.hlt) state_d = ST_HALT;
            end
        end
    end

    // Scoreboard countdown; a delivered load restarts its destination counter.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            pend_d[i] = (pend_q[i] != '0) ? pend_q[i] - CNT_W'(1) : '0;
        end
        if (out_hs && ctl_q.mem_rd && ctl_q.wr_reg != '0)
            pend_d[ctl_q.wr_reg] = CNT_W'(LD_LAT);
        pend_d[0] = '0;
    end

    // State, output bundle and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            ctl_q       <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) pend_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            ctl_q       <= ctl_d;
            for (int unsigned i = 0; i < NUM_REGS; i++) pend_q[i] <= pend_d[i];
        end
    end

    assign out_valid = out_valid_q;
    assign rd_en1    = ctl_q.rd_en1;
    assign rd_en2    = ctl_q.rd_en2;
    assign wr_en     = ctl_q.wr_en;
    assign mem_rd    = ctl_q.mem_rd;
    assign mem_wr    = ctl_q.mem_wr;
    assign saw_br    = ctl_q.saw_br;
    assign saw_j     = ctl_q.saw_j;
    assign alu_src   = ctl_q.alu_src;
    assign hlt       = ctl_q.hlt;
    assign rd_reg1   = ctl_q.rd_reg1;
    assign rd_reg2   = ctl_q.rd_reg2;
    assign wr_reg    = ctl_q.wr_reg;
    assign alu_op    = ctl_q.alu_op;
    assign sh_amt    = ctl_q.sh_amt;
    assign halted    = (state_q == ST_HALT);

`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles a valid instruction is held back by a hazard.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && state_q == ST_RUN && !flush && hazard && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Self-checking bench for decode_pipe_ctrl: directed scenarios plus a random
// run compared against a transaction-level reference model.
module tb_decode_pipe_ctrl;

    localparam int unsigned LD_LAT = 2;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_ADDZ = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3;
    localparam logic [3:0] OP_NOR = 4'd4,  OP_SLL  = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7;
    localparam logic [3:0] OP_LW  = 4'd8,  OP_SW   = 4'd9,  OP_LHB = 4'd10, OP_LLB = 4'd11;
    localparam logic [3:0] OP_B   = 4'd12, OP_JAL  = 4'd13, OP_JR  = 4'd14, OP_HLT = 4'd15;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_NOR = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4, ALU_SRL = 4'd5, ALU_SRA = 4'd6, ALU_LHB = 4'd7;
    localparam logic [3:0] ALU_NOP = 4'd15;

    typedef struct packed {
        logic       rd_en1, rd_en2, wr_en, mem_rd, mem_wr, saw_br, saw_j, alu_src, hlt;
        logic [3:0] rd_reg1, rd_reg2, wr_reg, alu_op, sh_amt;
    } ctl_t;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, z_flag, flush, out_valid, out_ready;
    logic [15:0] instr;
    logic rd_en1, rd_en2, wr_en, mem_rd, mem_wr, saw_br, saw_j, alu_src, hlt, halted;
    logic [3:0] rd_reg1, rd_reg2, wr_reg, alu_op, sh_amt;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    decode_pipe_ctrl #(.OPC_W(4), .REG_AW(4), .LD_LAT(LD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .z_flag(z_flag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd_en1(rd_en1), .rd_en2(rd_en2), .wr_en(wr_en), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .saw_br(saw_br), .saw_j(saw_j), .alu_src(alu_src),
        .hlt(hlt), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .wr_reg(wr_reg),
        .alu_op(alu_op), .sh_amt(sh_amt), .halted(halted)
`ifdef STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    ctl_t dut_b;
    assign dut_b = {rd_en1, rd_en2, wr_en, mem_rd, mem_wr, saw_br, saw_j, alu_src, hlt,
                    rd_reg1, rd_reg2, wr_reg, alu_op, sh_amt};

    // Reference decode: one row per opcode, straight from the ISA rules.
    function automatic ctl_t ref_decode(input logic [15:0] ins, input logic z);
        ctl_t c;
        logic [3:0] rd, rs, rt;
        rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
        c = '0;
        c.rd_reg1 = rs; c.rd_reg2 = rt; c.wr_reg = rd; c.sh_amt = rt; c.alu_op = ALU_NOP;
        case (ins[15:12])
            OP_ADD:  begin c.rd_en1 = 1; c.rd_en2 = 1; c.wr_en = 1; c.alu_src = 1; c.alu_op = ALU_ADD; end
            OP_ADDZ: begin c.rd_en1 = 1; c.rd_en2 = 1; c.wr_en = z; c.alu_src = 1; c.alu_op = ALU_ADD; end
            OP_SUB:  begin c.rd_en1 = 1; c.rd_en2 = 1; c.wr_en = 1; c.alu_src = 1; c.alu_op = ALU_SUB; end
            OP_AND:  begin c.rd_en1 = 1; c.rd_en2 = 1; c.wr_en = 1; c.alu_src = 1; c.alu_op = ALU_AND; end
            OP_NOR:  begin c.rd_en1 = 1; c.rd_en2 = 1; c.wr_en = 1; c.alu_src = 1; c.alu_op = ALU_NOR; end
            OP_SLL:  begin c.rd_en1 = 1; c.wr_en = 1; c.alu_op = ALU_SLL; end
            OP_SRL:  begin c.rd_en1 = 1; c.wr_en = 1; c.alu_op = ALU_SRL; end
            OP_SRA:  begin c.rd_en1 = 1; c.wr_en = 1; c.alu_op = ALU_SRA; end
            OP_LW:   begin c.rd_en1 = 1; c.wr_en = 1; c.mem_rd = 1; c.alu_op = ALU_ADD; end
            OP_SW:   begin c.rd_en1 = 1; c.rd_en2 = 1; c.mem_wr = 1; c.rd_reg2 = rd; c.alu_op = ALU_ADD; end
            OP_LHB:  begin c.rd_en1 = 1; c.wr_en = 1; c.rd_reg1 = rd; c.alu_op = ALU_LHB; end
            OP_LLB:  begin c.rd_en1 = 1; c.wr_en = 1; c.rd_reg1 = 4'd0; c.alu_op = ALU_ADD; end
            OP_B:    c.saw_br = 1;
            OP_JAL:  begin c.wr_en = 1; c.wr_reg = 4'hF; c.saw_j = 1; end
            OP_JR:   begin c.rd_en1 = 1; c.rd_en2 = 1; c.alu_src = 1; c.rd_reg1 = 4'hF;
                           c.rd_reg2 = 4'd0; c.saw_j = 1; c.alu_op = ALU_ADD; end
            default: c.hlt = 1;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt);
        return {op, rd, rs, rt};
    endfunction

    // Reference model state: pending loads kept as "busy until cycle" stamps.
    logic m_ov;
    ctl_t m_b;
    logic m_halt;
    int   cyc;
    int   busy_until [16];
    int   m_stall;

    function automatic logic m_haz(input ctl_t d);
        logic h;
        h = 1'b0;
        if (d.rd_en1 && d.rd_reg1 != 4'd0 && (cyc <= busy_until[d.rd_reg1] ||
            (m_ov && m_b.mem_rd && m_b.wr_reg == d.rd_reg1))) h = 1'b1;
        if (d.rd_en2 && d.rd_reg2 != 4'd0 && (cyc <= busy_until[d.rd_reg2] ||
            (m_ov && m_b.mem_rd && m_b.wr_reg == d.rd_reg2))) h = 1'b1;
        return h;
    endfunction

    function automatic logic m_ir();
        return !m_halt && !flush && !m_haz(ref_decode(instr, z_flag)) && (!m_ov || out_ready);
    endfunction

    // Advance the reference model once per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ov <= 1'b0; m_b <= '0; m_halt <= 1'b0; cyc <= 0; m_stall <= 0;
            for (int i = 0; i < 16; i++) busy_until[i] <= -1;
        end else begin
            cyc <= cyc + 1;
            if (in_valid && !m_halt && !flush && m_haz(ref_decode(instr, z_flag)) && m_stall < 65535)
                m_stall <= m_stall + 1;
            if (m_ov && out_ready && !flush && m_b.mem_rd && m_b.wr_reg != 4'd0)
                busy_until[m_b.wr_reg] <= cyc + int'(LD_LAT);
            if (flush) begin
                m_ov <= 1'b0;
                if (m_ov && m_b.hlt) m_halt <= 1'b0;
            end else if (!m_ov || out_ready) begin
                if (in_valid && m_ir()) begin
                    m_ov <= 1'b1;
                    m_b  <= ref_decode(instr, z_flag);
                    if (instr[15:12] == OP_HLT) m_halt <= 1'b1;
                end else begin
                    m_ov <= 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic [15:0] ins, input logic z,
                         input logic fl, input logic ordy);
        in_valid = iv; instr = ins; z_flag = z; flush = fl; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if ({wr_en, mem_rd, hlt, alu_op} !== 7'd0) begin failures++; $display("FAIL reset_ctl got=%b exp=0", {wr_en, mem_rd, hlt, alu_op}); end
        #3 rst_n = 1'b1;
        tick();
        drive(1, mk(OP_LW, 3, 1, 0), 0, 0, 1); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_first_accept got=%b exp=1", in_ready); end
        tick();
        drive(1, mk(OP_ADD, 5, 6, 7), 0, 0, 1);
        tick();
        drive(1, mk(OP_ADD, 4, 3, 2), 0, 0, 0); #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_pre_stall got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL reset_pre_valid got=%b exp=1", out_valid); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_async_valid got=%b exp=0", out_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_async_halted got=%b exp=0", halted); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_pending_clear in_ready got=%b exp=1", in_ready); end
        drive(0, 16'h0, 0, 0, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1, mk(OP_ADD, 1, 2, 3), 0, 0, 1); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || wr_reg !== 4'd1 || alu_op !== ALU_ADD) begin failures++;
            $display("FAIL b2b_add got v=%b wr=%0d op=%0d exp v=1 wr=1 op=%0d", out_valid, wr_reg, alu_op, ALU_ADD); end
        drive(1, mk(OP_SUB, 4, 1, 5), 0, 0, 1); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || rd_reg1 !== 4'd1 || wr_reg !== 4'd4 || alu_op !== ALU_SUB) begin failures++;
            $display("FAIL b2b_sub got v=%b r1=%0d wr=%0d op=%0d exp v=1 r1=1 wr=4 op=%0d", out_valid, rd_reg1, wr_reg, alu_op, ALU_SUB); end
        drive(0, 16'h0, 0, 0, 1);
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_load_use();
        int stalls;
`ifdef STALL_CNT_EN
        logic [15:0] sc0;
        sc0 = stall_cnt;
`endif
        drive(1, mk(OP_LW, 3, 1, 0), 0, 0, 1);
        tick();
        checks++; if (out_valid !== 1'b1 || mem_rd !== 1'b1 || wr_reg !== 4'd3) begin failures++;
            $display("FAIL lu_lw got v=%b mr=%b wr=%0d exp v=1 mr=1 wr=3", out_valid, mem_rd, wr_reg); end
        drive(1, mk(OP_ADD, 4, 3, 2), 0, 0, 1); #1;
        stalls = 0;
        while (in_ready !== 1'b1 && stalls < 20) begin
            stalls++;
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble cycle=%0d got=%b exp=0", stalls, out_valid); end
        end
        checks++; if (stalls != int'(LD_LAT) + 1) begin failures++; $display("FAIL lu_stall_len got=%0d exp=%0d", stalls, LD_LAT + 1); end
        tick();
        checks++; if (out_valid !== 1'b1 || wr_reg !== 4'd4 || rd_reg1 !== 4'd3) begin failures++;
            $display("FAIL lu_add got v=%b wr=%0d r1=%0d exp v=1 wr=4 r1=3", out_valid, wr_reg, rd_reg1); end
`ifdef STALL_CNT_EN
        checks++; if (stall_cnt - sc0 !== 16'(LD_LAT + 1)) begin failures++;
            $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt - sc0, LD_LAT + 1); end
`endif
        drive(1, mk(OP_LW, 0, 1, 0), 0, 0, 1);
        tick();
        drive(1, mk(OP_ADD, 5, 1, 2), 0, 0, 1); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_r0_nostall0 got=%b exp=1", in_ready); end
        tick();
        drive(1, mk(OP_SUB, 6, 1, 2), 0, 0, 1); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_r0_nostall1 got=%b exp=1", in_ready); end
        tick();
        drive(0, 16'h0, 0, 0, 1);
        tick();
    endtask

    task automatic test_backpressure();
        drive(1, mk(OP_ADD, 1, 2, 3), 0, 0, 0);
        tick();
        drive(1, mk(OP_SUB, 4, 5, 6), 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cycle=%0d got=%b exp=0", k, in_ready); end
            checks++; if (out_valid !== 1'b1 || wr_reg !== 4'd1 || rd_reg1 !== 4'd2 || rd_reg2 !== 4'd3 ||
                          alu_op !== ALU_ADD || wr_en !== 1'b1 || alu_src !== 1'b1) begin failures++;
                $display("FAIL bp_hold cycle=%0d got v=%b wr=%0d r1=%0d r2=%0d op=%0d exp v=1 wr=1 r1=2 r2=3 op=0",
                         k, out_valid, wr_reg, rd_reg1, rd_reg2, alu_op); end
            tick();
        end
        drive(1, mk(OP_SUB, 4, 5, 6), 0, 0, 1); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || alu_op !== ALU_SUB || wr_reg !== 4'd4) begin failures++;
            $display("FAIL bp_next got v=%b op=%0d wr=%0d exp v=1 op=1 wr=4", out_valid, alu_op, wr_reg); end
        drive(0, 16'h0, 0, 0, 1);
        tick();
    endtask

    task automatic test_addz();
        drive(1, mk(OP_ADDZ, 1, 2, 3), 0, 0, 1);
        tick();
        checks++; if (out_valid !== 1'b1 || wr_en !== 1'b0 || alu_op !== ALU_ADD) begin failures++;
            $display("FAIL addz_z0 got v=%b we=%b op=%0d exp v=1 we=0 op=0", out_valid, wr_en, alu_op); end
        drive(1, mk(OP_ADDZ, 1, 2, 3), 1, 0, 1);
        tick();
        checks++; if (out_valid !== 1'b1 || wr_en !== 1'b1 || alu_op !== ALU_ADD) begin failures++;
            $display("FAIL addz_z1 got v=%b we=%b op=%0d exp v=1 we=1 op=0", out_valid, wr_en, alu_op); end
        drive(0, 16'h0, 0, 0, 1);
        tick();
    endtask

    task automatic test_halt();
        drive(1, mk(OP_HLT, 0, 0, 0), 0, 0, 0);
        tick();
        checks++; if (halted !== 1'b1 || out_valid !== 1'b1 || hlt !== 1'b1) begin failures++;
            $display("FAIL halt_enter got h=%b v=%b hlt=%b exp 1 1 1", halted, out_valid, hlt); end
        drive(0, 16'h0, 0, 0, 0); #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL halt_ready got=%b exp=0", in_ready); end
        drive(0, 16'h0, 0, 1, 0); #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL halt_flush_ready got=%b exp=0", in_ready); end
        tick();
        drive(0, 16'h0, 0, 0, 0); #1;
        checks++; if (halted !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
            $display("FAIL halt_wrongpath got h=%b v=%b rdy=%b exp 0 0 1", halted, out_valid, in_ready); end
        drive(1, mk(OP_HLT, 0, 0, 0), 0, 0, 1);
        tick();
        checks++; if (halted !== 1'b1 || out_valid !== 1'b1) begin failures++;
            $display("FAIL halt_reenter got h=%b v=%b exp 1 1", halted, out_valid); end
        drive(0, 16'h0, 0, 0, 1);
        tick();
        checks++; if (halted !== 1'b1 || out_valid !== 1'b0) begin failures++;
            $display("FAIL halt_delivered got h=%b v=%b exp 1 0", halted, out_valid); end
        drive(0, 16'h0, 0, 1, 1);
        tick();
        drive(1, mk(OP_ADD, 1, 2, 3), 0, 0, 1); #1;
        checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin failures++;
            $display("FAIL halt_late_flush got h=%b rdy=%b exp 1 0", halted, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL halt_no_issue got=%b exp=0", out_valid); end
        drive(0, 16'h0, 0, 0, 0);
        #2 rst_n = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        tick();
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_reset got=%b exp=0", halted); end
    endtask

    task automatic test_random();
        logic [3:0] op, rd, rs, rt;
        for (int i = 0; i < 3000; i++) begin
            op = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 99) < 25) op = OP_LW;
            rd = 4'($urandom_range(0, 3));
            rs = 4'($urandom_range(0, 3));
            rt = 4'($urandom_range(0, 3));
            drive(logic'($urandom_range(0, 99) < 75), mk(op, rd, rs, rt), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 99) < 6), logic'($urandom_range(0, 99) < 70));
            #1;
            checks++; if (in_ready !== m_ir()) begin failures++;
                $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", i, in_ready, m_ir()); end
            checks++; if (out_valid !== m_ov) begin failures++;
                $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", i, out_valid, m_ov); end
            if (m_ov) begin
                checks++; if (dut_b !== m_b) begin failures++;
                    $display("FAIL rnd_bundle cyc=%0d got=%h exp=%h", i, dut_b, m_b); end
            end
            checks++; if (halted !== m_halt) begin failures++;
                $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", i, halted, m_halt); end
`ifdef STALL_CNT_EN
            checks++; if (int'(stall_cnt) != m_stall) begin failures++;
                $display("FAIL rnd_stall_cnt cyc=%0d got=%0d exp=%0d", i, stall_cnt, m_stall); end
`endif
            tick();
        end
        drive(0, 16'h0, 0, 0, 1);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 16'h0, 0, 0, 0);
        test_reset();
        test_back_to_back();
        test_load_use();
        test_backpressure();
        test_addz();
        test_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
